// File: rtl/spi_reg_pkg.sv
// +------------------------------------------------------------------+
// | spi_reg_pkg : shared constants and FSM state type for the SPI    |
// | register slave.                                  rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int RW_BIT     = 7;
  localparam int ADDR_MSB   = 6;
  localparam int ADDR_LSB   = 3;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// +------------------------------------------------------------------+
// | spi_sync_edge : synchronises sclk/ssn/mosi into clk and detects  |
// | sclk rising/falling edges.                       rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sclk,
  input  logic ssn,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ssn_sync,
  output logic mosi_sync
);

  logic [SYNC_STAGES-1:0] sclk_pipe;
  logic [SYNC_STAGES-1:0] ssn_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sclk_last;

  // sclk and ssn reset to their idle-high levels so no edge or select is seen out of reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_pipe <= '1;
      ssn_pipe  <= '1;
      mosi_pipe <= '0;
      sclk_last <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
      ssn_pipe  <= {ssn_pipe[SYNC_STAGES-2:0], ssn};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
      sclk_last <= sclk_pipe[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_pipe[SYNC_STAGES-1] & ~sclk_last;
  assign sclk_fall = ~sclk_pipe[SYNC_STAGES-1] & sclk_last;
  assign ssn_sync  = ssn_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_reg_slave.sv
// +------------------------------------------------------------------+
// | spi_reg_slave : SPI mode-3 responder decoding 16-bit register    |
// | read/write frames into single-cycle strobes.     rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sclk,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [3:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_stb,
  output logic       rd_stb,
  input  logic [7:0] rd_data,
  output logic       frame_err
);

  localparam int SHIFT_W = CMD_BITS - 1;

  logic               sclk_rise;
  logic               sclk_fall;
  logic               ssn_sync;
  logic               mosi_sync;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SHIFT_W-1:0] shift_in;
  logic [7:0]         tx_shift;
  logic               is_read;
  logic               load_tx;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .sclk      (sclk),
    .ssn       (ssn),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ssn_sync  (ssn_sync),
    .mosi_sync (mosi_sync)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      tx_shift  <= '0;
      is_read   <= 1'b0;
      load_tx   <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      reg_addr  <= '0;
      wr_data   <= '0;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      frame_err <= 1'b0;

      // Deselect overrides any sclk edge seen in the same cycle
      if (ssn_sync) begin
        if (state == CMD || state == DATA) begin
          frame_err <= 1'b1;
        end
        state   <= IDLE;
        bit_cnt <= '0;
        load_tx <= 1'b0;
        miso_oe <= 1'b0;
        miso    <= MISO_IDLE;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
            miso_oe <= 1'b1;
            miso    <= MISO_IDLE;
          end

          CMD: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[SHIFT_W-2:0], mosi_sync};
              bit_cnt  <= bit_cnt + 1'b1;
              // The 8th bit (LSB of byte 0) is a reserved zero, so rw/addr already sit in shift_in
              if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                is_read  <= shift_in[RW_BIT-1];
                reg_addr <= shift_in[ADDR_MSB-1:ADDR_LSB-1];
                rd_stb   <= shift_in[RW_BIT-1];
                state    <= DATA;
              end
            end
          end

          DATA: begin
            // rd_stb is seen by the register file this cycle; its data is valid one clk later
            load_tx <= rd_stb;
            if (load_tx) begin
              tx_shift <= rd_data;
            end else if (sclk_fall && is_read) begin
              miso     <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if (sclk_rise) begin
              shift_in <= {shift_in[SHIFT_W-2:0], mosi_sync};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                if (!is_read) begin
                  wr_data <= {shift_in, mosi_sync};
                  wr_stb  <= 1'b1;
                end
                miso  <= MISO_IDLE;
                state <= DONE;
              end
            end
          end

          DONE: begin
            miso <= MISO_IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
// +------------------------------------------------------------------+
// | tb_spi_reg_slave : directed, table-driven bench for the SPI      |
// | register slave.                                  rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module tb_spi_reg_slave;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sclk = 1'b1;
  logic       ssn = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [3:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_stb;
  logic       rd_stb;
  logic [7:0] rd_data = 8'h00;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         fe_cnt = 0;
  logic [3:0] wr_addr_seen = '0;
  logic [7:0] wr_data_seen = '0;
  logic [3:0] rd_addr_seen = '0;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  dat;
    logic [7:0]  rdd;
    logic [15:0] exp_rx;
    int          exp_wr;
    int          exp_rd;
    logic [3:0]  exp_addr;
    logic [7:0]  exp_wdata;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  spi_reg_slave dut (
    .clk       (clk),
    .rstn      (rstn),
    .sclk      (sclk),
    .ssn       (ssn),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb),
    .rd_data   (rd_data),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt++;
      wr_addr_seen = reg_addr;
      wr_data_seen = wr_data;
    end
    if (rd_stb) begin
      rd_cnt++;
      rd_addr_seen = reg_addr;
    end
    if (frame_err) fe_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 3: mosi changes with sclk low, miso is captured at the rising edge
  task automatic host_bits(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = tx[nbits-1-i];
      wait_clks(HALF);
      sclk = 1'b1;
      rx   = {rx[22:0], miso};
      wait_clks(HALF);
    end
  endtask

  task automatic host_frame(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
    ssn = 1'b0;
    wait_clks(HALF);
    host_bits(tx, nbits, rx);
    wait_clks(HALF);
    ssn = 1'b1;
    wait_clks(10);
  endtask

  initial begin
    logic [23:0] rx;
    int wr0, rd0, fe0;

    vecs[0] = '{cmd:8'hE8, dat:8'h00, rdd:8'h30, exp_rx:16'h0030, exp_wr:0, exp_rd:1, exp_addr:4'hD, exp_wdata:8'h00};
    vecs[1] = '{cmd:8'h10, dat:8'h01, rdd:8'h00, exp_rx:16'h0000, exp_wr:1, exp_rd:0, exp_addr:4'h2, exp_wdata:8'h01};
    vecs[2] = '{cmd:8'h90, dat:8'h00, rdd:8'h01, exp_rx:16'h0001, exp_wr:0, exp_rd:1, exp_addr:4'h2, exp_wdata:8'h01};
    vecs[3] = '{cmd:8'hF8, dat:8'h00, rdd:8'h8F, exp_rx:16'h008F, exp_wr:0, exp_rd:1, exp_addr:4'hF, exp_wdata:8'h01};
    vecs[4] = '{cmd:8'h10, dat:8'h01, rdd:8'h00, exp_rx:16'h0000, exp_wr:1, exp_rd:0, exp_addr:4'h2, exp_wdata:8'h01};
    vecs[5] = '{cmd:8'h30, dat:8'h02, rdd:8'h00, exp_rx:16'h0000, exp_wr:1, exp_rd:0, exp_addr:4'h6, exp_wdata:8'h02};
    vecs[6] = '{cmd:8'h50, dat:8'h04, rdd:8'h00, exp_rx:16'h0000, exp_wr:1, exp_rd:0, exp_addr:4'hA, exp_wdata:8'h04};

    wait_clks(3);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_reg_addr", {28'd0, reg_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_strobes", {29'd0, wr_stb, rd_stb, frame_err}, 32'd0);
    rstn = 1'b1;
    wait_clks(5);

    for (int i = 0; i < 7; i++) begin
      rd_data = vecs[i].rdd;
      wr0 = wr_cnt; rd0 = rd_cnt; fe0 = fe_cnt;
      host_frame({8'h00, vecs[i].cmd, vecs[i].dat}, 16, rx);
      chk($sformatf("v%0d_rx", i), {16'd0, rx[15:0]}, {16'd0, vecs[i].exp_rx});
      chk($sformatf("v%0d_wr_cnt", i), wr_cnt - wr0, vecs[i].exp_wr);
      chk($sformatf("v%0d_rd_cnt", i), rd_cnt - rd0, vecs[i].exp_rd);
      chk($sformatf("v%0d_frame_err", i), fe_cnt - fe0, 0);
      chk($sformatf("v%0d_reg_addr", i), {28'd0, reg_addr}, {28'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_wr_data", i), {24'd0, wr_data}, {24'd0, vecs[i].exp_wdata});
      chk($sformatf("v%0d_miso_oe", i), {31'd0, miso_oe}, 32'd0);
      if (vecs[i].exp_wr != 0) begin
        chk($sformatf("v%0d_stb_addr", i), {28'd0, wr_addr_seen}, {28'd0, vecs[i].exp_addr});
        chk($sformatf("v%0d_stb_data", i), {24'd0, wr_data_seen}, {24'd0, vecs[i].exp_wdata});
      end
      if (vecs[i].exp_rd != 0) begin
        chk($sformatf("v%0d_rd_addr", i), {28'd0, rd_addr_seen}, {28'd0, vecs[i].exp_addr});
      end
    end

    // Abort after the command byte of a write
    wr0 = wr_cnt; fe0 = fe_cnt;
    host_frame(24'h000010, 8, rx);
    chk("abort_frame_err", fe_cnt - fe0, 1);
    chk("abort_no_wr", wr_cnt - wr0, 0);
    chk("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
    wr0 = wr_cnt; fe0 = fe_cnt;
    host_frame(24'h001000, 16, rx);
    chk("post_abort_wr", wr_cnt - wr0, 1);
    chk("post_abort_addr", {28'd0, wr_addr_seen}, 32'h2);
    chk("post_abort_data", {24'd0, wr_data_seen}, 32'h00);
    chk("post_abort_fe", fe_cnt - fe0, 0);

    // Overrun: 8 extra sclks after a complete write frame
    wr0 = wr_cnt; fe0 = fe_cnt;
    host_frame(24'h505AFF, 24, rx);
    chk("overrun_wr_cnt", wr_cnt - wr0, 1);
    chk("overrun_wr_data", {24'd0, wr_data}, 32'h5A);
    chk("overrun_addr", {28'd0, reg_addr}, 32'hA);
    chk("overrun_miso", {8'd0, rx}, 32'd0);
    chk("overrun_fe", fe_cnt - fe0, 0);

    // Reset in the middle of a write frame
    wr0 = wr_cnt;
    ssn = 1'b0;
    wait_clks(HALF);
    host_bits(24'h0010AA, 12, rx);
    chk("pre_rst_oe", {31'd0, miso_oe}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("mid_rst_reg_addr", {28'd0, reg_addr}, 32'd0);
    chk("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("mid_rst_outs", {28'd0, miso, wr_stb, rd_stb, frame_err}, 32'd0);
    ssn  = 1'b1;
    sclk = 1'b1;
    wait_clks(3);
    rstn = 1'b1;
    wait_clks(5);
    chk("mid_rst_no_wr", wr_cnt - wr0, 0);

    rd_data = 8'h30;
    rd0 = rd_cnt; wr0 = wr_cnt;
    host_frame(24'h00E800, 16, rx);
    chk("post_rst_rx", {16'd0, rx[15:0]}, 32'h0030);
    chk("post_rst_rd_cnt", rd_cnt - rd0, 1);
    chk("post_rst_addr", {28'd0, rd_addr_seen}, 32'hD);
    chk("post_rst_no_wr", wr_cnt - wr0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
